// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store engine for RV32. It accepts one load or store from
//   the execute/memory pipeline register and checks funct3 legality and
//   alignment. It builds size, byte strobes and lane-replicated store data,
//   then runs the request/response handshake with the memory wrapper. Finally
//   it returns the extracted, sign/zero-extended load value or an exception to
//   writeback. Only one transaction is in flight at a time.
//
// Handshakes: every channel uses valid/ready. A beat transfers on a rising
// clk_i edge where both valid and ready are high. A raised valid is never
// withdrawn, and its payload stays unchanged until that transfer.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   op_valid_i/op_ready_o    operation handshake from the pipeline
//   op_store_i, op_funct3_i  operation kind and RV32 funct3
//   op_addr_i, op_wdata_i    effective address and store source
//   flush_i                  pipeline flush (result of the pending op dropped)
//   data_req_*               request channel to the memory wrapper
//   data_rsp_*               response channel from the memory wrapper
//   res_valid_o/res_ready_i  result handshake to writeback
//   res_data_o, res_exc_o, res_exc_cause_o  load value / exception + mcause
//   busy_o                   high whenever the FSM is outside IDLE
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic                  op_store_i,
  input  logic [2:0]            op_funct3_i,
  input  logic [ADDR_WIDTH-1:0] op_addr_i,
  input  logic [DATA_WIDTH-1:0] op_wdata_i,
  input  logic                  flush_i,
  output logic                  data_req_valid_o,
  input  logic                  data_req_ready_i,
  output logic [ADDR_WIDTH-1:0] data_req_addr_o,
  output logic                  data_req_write_o,
  output logic [2:0]            data_req_size_o,
  output logic [DATA_WIDTH-1:0] data_req_data_o,
  output logic [3:0]            data_req_strb_o,
  input  logic                  data_rsp_valid_i,
  output logic                  data_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0] data_rsp_data_i,
  input  logic                  data_rsp_error_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_exc_o,
  output logic [3:0]            res_exc_cause_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_write_q, req_write_d;
  logic [2:0]            req_size_q, req_size_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic [3:0]            req_strb_q, req_strb_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_exc_q, res_exc_d;
  logic [3:0]            res_cause_q, res_cause_d;

  // Accept-time decode of the incoming operation
  logic                  op_illegal;
  logic                  op_misaligned;
  logic [3:0]            op_strb;
  logic [DATA_WIDTH-1:0] op_wdata;

  always_comb begin
    // Legal loads: LB LH LW LBU LHU. Legal stores: SB SH SW.
    if (op_store_i) begin
      op_illegal = op_funct3_i[2] | (op_funct3_i[1:0] == 2'b11);
    end else begin
      op_illegal = (op_funct3_i[1:0] == 2'b11) | (op_funct3_i == 3'b110);
    end

    op_misaligned = ((op_funct3_i[1:0] == 2'b01) & op_addr_i[0]) |
                    ((op_funct3_i[1:0] == 2'b10) & (op_addr_i[1:0] != 2'b00));

    op_strb  = 4'b1111;
    op_wdata = '0;
    if (op_store_i) begin
      case (op_funct3_i[1:0])
        2'b00: begin
          op_strb  = 4'b0001 << op_addr_i[1:0];
          op_wdata = {4{op_wdata_i[7:0]}};
        end
        2'b01: begin
          op_strb  = 4'b0011 << op_addr_i[1:0];
          op_wdata = {2{op_wdata_i[15:0]}};
        end
        default: begin
          op_strb  = 4'b1111;
          op_wdata = op_wdata_i;
        end
      endcase
    end
  end

  // Load extraction: move the addressed lane down to bit 0, then extend
  logic [DATA_WIDTH-1:0] rsp_shift;
  logic [DATA_WIDTH-1:0] load_val;

  assign rsp_shift = data_rsp_data_i >> {req_addr_q[1:0], 3'b000};

  always_comb begin
    load_val = data_rsp_data_i;
    case (funct3_q)
      3'b000:  load_val = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
      3'b100:  load_val = {24'b0, rsp_shift[7:0]};
      3'b001:  load_val = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
      3'b101:  load_val = {16'b0, rsp_shift[15:0]};
      default: load_val = data_rsp_data_i;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    req_addr_d  = req_addr_q;
    req_write_d = req_write_q;
    req_size_d  = req_size_q;
    req_data_d  = req_data_q;
    req_strb_d  = req_strb_q;
    funct3_d    = funct3_q;
    res_data_d  = res_data_q;
    res_exc_d   = res_exc_q;
    res_cause_d = res_cause_q;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (op_valid_i && !flush_i) begin
          if (op_illegal) begin
            res_data_d  = '0;
            res_exc_d   = 1'b1;
            res_cause_d = op_store_i ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            state_d     = S_DONE;
          end else if (op_misaligned) begin
            res_data_d  = '0;
            res_exc_d   = 1'b1;
            res_cause_d = op_store_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            state_d     = S_DONE;
          end else begin
            req_addr_d  = op_addr_i;
            req_write_d = op_store_i;
            req_size_d  = {1'b0, op_funct3_i[1:0]};
            req_data_d  = op_wdata;
            req_strb_d  = op_strb;
            funct3_d    = op_funct3_i;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        // A flush cannot retract the request; remember it instead.
        if (flush_i) kill_d = 1'b1;
        if (data_req_ready_i) state_d = S_RSP;
      end

      S_RSP: begin
        if (flush_i) kill_d = 1'b1;
        if (data_rsp_valid_i) begin
          if (kill_q || flush_i) begin
            // Response drained and discarded.
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            if (data_rsp_error_i) begin
              res_data_d  = '0;
              res_exc_d   = 1'b1;
              res_cause_d = req_write_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end else begin
              res_data_d  = req_write_q ? '0 : load_val;
              res_exc_d   = 1'b0;
              res_cause_d = 4'd0;
            end
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (res_ready_i || flush_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_size_q  <= 3'b000;
      req_data_q  <= '0;
      req_strb_q  <= 4'b0000;
      funct3_q    <= 3'b000;
      res_data_q  <= '0;
      res_exc_q   <= 1'b0;
      res_cause_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      req_addr_q  <= req_addr_d;
      req_write_q <= req_write_d;
      req_size_q  <= req_size_d;
      req_data_q  <= req_data_d;
      req_strb_q  <= req_strb_d;
      funct3_q    <= funct3_d;
      res_data_q  <= res_data_d;
      res_exc_q   <= res_exc_d;
      res_cause_q <= res_cause_d;
    end
  end

  assign op_ready_o       = (state_q == S_IDLE);
  assign busy_o           = (state_q != S_IDLE);
  assign data_req_valid_o = (state_q == S_REQ);
  assign data_rsp_ready_o = (state_q == S_RSP);
  assign res_valid_o      = (state_q == S_DONE);
  assign data_req_addr_o  = req_addr_q;
  assign data_req_write_o = req_write_q;
  assign data_req_size_o  = req_size_q;
  assign data_req_data_o  = req_data_q;
  assign data_req_strb_o  = req_strb_q;
  assign res_data_o       = res_data_q;
  assign res_exc_o        = res_exc_q;
  assign res_exc_cause_o  = res_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Bench for load_store_unit. A cycle-accurate driver plays pipeline, memory
//   and writeback. A transaction-level model supplies the expected request
//   payload and result of each operation. One compare process checks every DUT
//   output against those expectations on each falling clock edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        op_valid_i, op_ready_o, op_store_i;
  logic [2:0]  op_funct3_i;
  logic [31:0] op_addr_i, op_wdata_i;
  logic        flush_i;
  logic        data_req_valid_o, data_req_ready_i;
  logic [31:0] data_req_addr_o;
  logic        data_req_write_o;
  logic [2:0]  data_req_size_o;
  logic [31:0] data_req_data_o;
  logic [3:0]  data_req_strb_o;
  logic        data_rsp_valid_i, data_rsp_ready_o;
  logic [31:0] data_rsp_data_i;
  logic        data_rsp_error_i;
  logic        res_valid_o, res_ready_i;
  logic [31:0] res_data_o;
  logic        res_exc_o;
  logic [3:0]  res_exc_cause_o;
  logic        busy_o;

  load_store_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_store_i(op_store_i),
    .op_funct3_i(op_funct3_i), .op_addr_i(op_addr_i), .op_wdata_i(op_wdata_i),
    .flush_i(flush_i),
    .data_req_valid_o(data_req_valid_o), .data_req_ready_i(data_req_ready_i),
    .data_req_addr_o(data_req_addr_o), .data_req_write_o(data_req_write_o),
    .data_req_size_o(data_req_size_o), .data_req_data_o(data_req_data_o),
    .data_req_strb_o(data_req_strb_o),
    .data_rsp_valid_i(data_rsp_valid_i), .data_rsp_ready_o(data_rsp_ready_o),
    .data_rsp_data_i(data_rsp_data_i), .data_rsp_error_i(data_rsp_error_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_exc_o(res_exc_o), .res_exc_cause_o(res_exc_cause_o), .busy_o(busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- counters and checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 inside {3'b000, 3'b001, 3'b010});
    return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  endfunction

  // {exc, cause} decided at accept; exc=0 means a memory request is issued
  function automatic logic [4:0] model_accept(input logic st, input logic [2:0] f3,
                                              input logic [31:0] a);
    int off = int'(a & 32'd3);
    if (!is_legal(st, f3)) return {1'b1, st ? 4'd7 : 4'd5};
    if ((off % nbytes(f3)) != 0) return {1'b1, st ? 4'd6 : 4'd4};
    return 5'd0;
  endfunction

  // {addr, write, size, data, strb}
  function automatic logic [71:0] model_req(input logic st, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] wd);
    int          nb  = nbytes(f3);
    int          off = int'(a & 32'd3);
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
    size = (nb == 1) ? 3'd0 : (nb == 2) ? 3'd1 : 3'd2;
    strb = 4'hF;
    data = 32'd0;
    if (st) begin
      strb = 4'(((1 << nb) - 1) << off);
      if (nb == 1)      data = 32'(wd[7:0]) * 32'h01010101;
      else if (nb == 2) data = 32'(wd[15:0]) * 32'h00010001;
      else              data = wd;
    end
    return {a, st, size, data, strb};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int     nb  = nbytes(f3);
    int     off = int'(a & 32'd3);
    longint v;
    longint full;
    if (nb == 4) return rd;
    full = longint'(1) << (8 * nb);
    v = longint'(rd >> (8 * off)) % full;
    if (!f3[2] && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction

  // ---------------- expectations shared with the compare process ----------------
  logic        chk_en        = 1'b0;
  logic        exp_idle      = 1'b1;
  logic        exp_req_valid = 1'b0;
  logic        exp_rsp_ready = 1'b0;
  logic        exp_res_valid = 1'b0;
  logic [71:0] exp_req       = '0;
  logic [36:0] exp_q[$];            // {exc, cause, data}
  logic [36:0] last_res;
  logic [71:0] last_req;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("op_ready",  72'(op_ready_o),       72'(exp_idle));
      check("busy",      72'(busy_o),           72'(!exp_idle));
      check("req_valid", 72'(data_req_valid_o), 72'(exp_req_valid));
      check("rsp_ready", 72'(data_rsp_ready_o), 72'(exp_rsp_ready));
      check("res_valid", 72'(res_valid_o),      72'(exp_res_valid));
      if (exp_req_valid) begin
        last_req = {data_req_addr_o, data_req_write_o, data_req_size_o,
                    data_req_data_o, data_req_strb_o};
        check("req_payload", last_req, exp_req);
      end
      if (exp_res_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_queue: result expected but scoreboard empty (t=%0t)", $time);
        end else begin
          check("res_value", 72'({res_exc_o, res_exc_cause_o, res_data_o}), 72'(exp_q[0]));
          if (res_ready_i || flush_i) begin
            last_res = {res_exc_o, res_exc_cause_o, res_data_o};
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // fl: 0 none, 1 flush while offering in IDLE, 2 flush in first REQ cycle,
  //     3 flush in first RSP cycle (only when rsp_wait>0), 4 flush in DONE
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic er,
                        input int req_wait, input int rsp_wait, input int res_wait,
                        input int fl);
    logic [4:0] acc;
    logic       killed;
    acc    = model_accept(st, f3, a);
    killed = 1'b0;
    op_store_i  = st;
    op_funct3_i = f3;
    op_addr_i   = a;
    op_wdata_i  = wd;
    op_valid_i  = 1'b1;
    if (fl == 1) begin
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
    end
    tick();  // accept edge
    op_valid_i  = 1'b0;
    op_addr_i   = $urandom;
    op_wdata_i  = $urandom;
    op_funct3_i = 3'($urandom_range(0, 7));
    op_store_i  = 1'($urandom_range(0, 1));
    exp_idle    = 1'b0;
    if (acc[4]) begin
      exp_q.push_back({1'b1, acc[3:0], 32'd0});
    end else begin
      exp_req_valid    = 1'b1;
      exp_req          = model_req(st, f3, a, wd);
      data_req_ready_i = (req_wait == 0);
      if (fl == 2) begin
        flush_i = 1'b1;
        killed  = 1'b1;
      end
      for (int i = 1; i <= req_wait; i++) begin
        tick();
        flush_i          = 1'b0;
        data_req_ready_i = (i == req_wait);
      end
      tick();  // request handshake edge
      flush_i          = 1'b0;
      data_req_ready_i = 1'b0;
      exp_req_valid    = 1'b0;
      exp_rsp_ready    = 1'b1;
      data_rsp_valid_i = (rsp_wait == 0);
      data_rsp_data_i  = (rsp_wait == 0) ? rd : $urandom;
      data_rsp_error_i = (rsp_wait == 0) ? er : 1'($urandom_range(0, 1));
      if (fl == 3 && rsp_wait > 0) begin
        flush_i = 1'b1;
        killed  = 1'b1;
      end
      for (int i = 1; i <= rsp_wait; i++) begin
        tick();
        flush_i          = 1'b0;
        data_rsp_valid_i = (i == rsp_wait);
        data_rsp_data_i  = (i == rsp_wait) ? rd : $urandom;
        data_rsp_error_i = (i == rsp_wait) ? er : 1'($urandom_range(0, 1));
      end
      if (!killed) begin
        if (er)      exp_q.push_back({1'b1, st ? 4'd7 : 4'd5, 32'd0});
        else if (st) exp_q.push_back(37'd0);
        else         exp_q.push_back({5'd0, model_load(f3, a, rd)});
      end
      tick();  // response edge
      data_rsp_valid_i = 1'b0;
      data_rsp_data_i  = $urandom;
      data_rsp_error_i = 1'b0;
      exp_rsp_ready    = 1'b0;
      if (killed) exp_idle = 1'b1;
    end
    if (!killed) begin
      exp_res_valid = 1'b1;
      if (fl == 4) begin
        res_ready_i = 1'b0;
        flush_i     = 1'b1;
        tick();
        flush_i = 1'b0;
      end else begin
        res_ready_i = (res_wait == 0);
        for (int i = 1; i <= res_wait; i++) begin
          tick();
          res_ready_i = (i == res_wait);
        end
        tick();
        res_ready_i = 1'b0;
      end
      exp_res_valid = 1'b0;
      exp_idle      = 1'b1;
    end
  endtask

  // Accept a load, then hit reset; optionally flush in REQ and reset in RSP.
  task automatic reset_mid(input logic in_rsp);
    op_store_i  = 1'b0;
    op_funct3_i = 3'b010;
    op_addr_i   = 32'h3000;
    op_wdata_i  = 32'h0;
    op_valid_i  = 1'b1;
    tick();
    op_valid_i    = 1'b0;
    exp_idle      = 1'b0;
    exp_req_valid = 1'b1;
    exp_req       = model_req(1'b0, 3'b010, 32'h3000, 32'h0);
    if (in_rsp) begin
      data_req_ready_i = 1'b1;
      flush_i          = 1'b1;
      tick();
      data_req_ready_i = 1'b0;
      flush_i          = 1'b0;
      exp_req_valid    = 1'b0;
      exp_rsp_ready    = 1'b1;
    end
    rst_i = 1'b1;
    tick();
    rst_i         = 1'b0;
    exp_req_valid = 1'b0;
    exp_rsp_ready = 1'b0;
    exp_idle      = 1'b1;
    check("rst_mid_req_addr", 72'(data_req_addr_o), 72'd0);
    check("rst_mid_res_data", 72'(res_data_o), 72'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    op_valid_i = 1'b0; op_store_i = 1'b0; op_funct3_i = 3'b0;
    op_addr_i = 32'd0; op_wdata_i = 32'd0; flush_i = 1'b0;
    data_req_ready_i = 1'b0; data_rsp_valid_i = 1'b0;
    data_rsp_data_i = 32'd0; data_rsp_error_i = 1'b0; res_ready_i = 1'b0;
    last_res = '0;
    last_req = '0;

    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_req_addr", 72'(data_req_addr_o), 72'd0);
    check("rst_req_strb", 72'(data_req_strb_o), 72'd0);
    check("rst_req_data", 72'(data_req_data_o), 72'd0);
    check("rst_res", 72'({res_exc_o, res_exc_cause_o, res_data_o}), 72'd0);

    // Model pins
    check("pin_lb",  72'(model_load(3'b000, 32'h1003, 32'h80FF0000)), 72'(32'hFFFFFF80));
    check("pin_lbu", 72'(model_load(3'b100, 32'h1003, 32'h80FF0000)), 72'(32'h00000080));
    check("pin_sh",  model_req(1'b1, 3'b001, 32'h2002, 32'h1234ABCD),
          {32'h2002, 1'b1, 3'b001, 32'hABCDABCD, 4'b1100});
    check("pin_sw_mis", 72'(model_accept(1'b1, 3'b010, 32'h1002)), 72'({1'b1, 4'd6}));

    // Directed cases
    run_op(1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 0);
    check("lw_req", last_req, {32'h1000, 1'b0, 3'b010, 32'h0, 4'b1111});
    check("lw_res", 72'(last_res), 72'({5'd0, 32'hDEADBEEF}));
    run_op(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF0000, 1'b0, 0, 0, 0, 0);
    check("lb_res", 72'(last_res), 72'({5'd0, 32'hFFFFFF80}));
    run_op(1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF0000, 1'b0, 0, 0, 0, 0);
    check("lbu_res", 72'(last_res), 72'({5'd0, 32'h00000080}));
    run_op(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h5555AAAA, 1'b0, 3, 0, 1, 0);
    check("sh_req", last_req, {32'h2002, 1'b1, 3'b001, 32'hABCDABCD, 4'b1100});
    check("sh_res", 72'(last_res), 72'd0);
    run_op(1'b0, 3'b010, 32'h1001, 32'h0, 32'h0, 1'b0, 0, 0, 0, 0);
    check("lw_mis_res", 72'(last_res), 72'({1'b1, 4'd4, 32'd0}));
    run_op(1'b1, 3'b010, 32'h1002, 32'h77, 32'h0, 1'b0, 0, 0, 0, 0);
    check("sw_mis_res", 72'(last_res), 72'({1'b1, 4'd6, 32'd0}));
    run_op(1'b0, 3'b001, 32'h10, 32'h0, 32'h12345678, 1'b1, 0, 1, 0, 0);
    check("lh_err_res", 72'(last_res), 72'({1'b1, 4'd5, 32'd0}));
    run_op(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b0, 0, 0, 0, 0);
    check("ld_f3_011_res", 72'(last_res), 72'({1'b1, 4'd5, 32'd0}));
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 0, 2, 0, 3);  // flush in RSP
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 1'b0, 1, 0, 0, 2);  // flush in REQ
    run_op(1'b1, 3'b000, 32'h47, 32'hA5, 32'h0, 1'b0, 0, 0, 0, 1);        // flush in IDLE
    check("sb_req", last_req, {32'h47, 1'b1, 3'b000, 32'hA5A5A5A5, 4'b1000});
    run_op(1'b0, 3'b101, 32'h4A, 32'h0, 32'h89AB0000, 1'b0, 0, 0, 2, 4);  // flush in DONE
    reset_mid(1'b0);
    reset_mid(1'b1);
    run_op(1'b0, 3'b001, 32'h52, 32'h0, 32'h8001_0000, 1'b0, 0, 0, 0, 0);
    check("lh_after_rst", 72'(last_res), 72'({5'd0, 32'hFFFF8001}));

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          fl;
      a  = $urandom;
      fl = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), fl);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    check("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage load/store engine that sits directly upstream of the memory wrapper's data port (data_req_*/data_rsp_*). It accepts one RV32 load or store from the execute/memory pipeline register and checks alignment. It generates size, byte strobes and lane-replicated store data, runs the valid/ready request/response handshake, then returns the extracted, sign/zero-extended load result or an exception to writeback. One transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 32, address width; must match the memory wrapper.
DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
op_valid_i  in  1  operation valid from pipeline
op_ready_o  out  1  unit can accept an operation
op_store_i  in  1  1=store, 0=load
op_funct3_i  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
op_addr_i  in  ADDR_WIDTH  effective address
op_wdata_i  in  32  store source (rs2)
flush_i  in  1  pipeline flush; suppresses the pending result
data_req_valid_o  out  1  to wrapper data_req_valid_i
data_req_ready_i  in  1  from wrapper data_req_ready_o
data_req_addr_o  out  ADDR_WIDTH  byte address, unmodified
data_req_write_o  out  1  write flag
data_req_size_o  out  3  000 byte, 001 half, 010 word
data_req_data_o  out  32  lane-replicated store data
data_req_strb_o  out  4  byte strobes
data_rsp_valid_i  in  1  response valid
data_rsp_ready_o  out  1  response ready
data_rsp_data_i  in  32  raw read word
data_rsp_error_i  in  1  response error
res_valid_o  out  1  result valid to writeback
res_ready_i  in  1  writeback accepts result
res_data_o  out  32  load value; 0 for stores/exceptions
res_exc_o  out  1  exception flag
res_exc_cause_o  out  4  mcause code
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: clk_i is the single clock. rst_i is synchronous and active-high.
- Reset state: state=IDLE and all registered outputs 0. Consequently op_ready_o=1 and busy_o=0 after reset.
- FSM states are IDLE, REQ, RSP and DONE. All request outputs come from registers latched at accept.
- IDLE:
  - op_ready_o=1.
  - An operation is accepted when op_valid_i & op_ready_o & !flush_i.
  - Illegal funct3 raises an access fault (load 5, store 7) and goes to DONE. Illegal means 011/110/111, or a store with funct3[2]=1.
  - Misalignment raises misaligned (load 4, store 6) and goes to DONE. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise the operation is latched and the FSM goes to REQ.
- REQ:
  - data_req_valid_o=1, with payload held stable until data_req_ready_i.
  - On handshake, go to RSP.
  - Valid is never retracted, including under flush.
- RSP:
  - data_rsp_ready_o=1.
  - On data_rsp_valid_i, capture the response and go to DONE, or to IDLE if killed.
  - data_rsp_error_i produces res_exc_o=1 with cause 5 (load) or 7 (store) and res_data_o=0.
- DONE:
  - res_valid_o=1, with the result held stable until res_ready_i.
  - Then go to IDLE.
- Latency: accept at cycle N gives req_valid at N+1. With zero-wait memory, rsp arrives at N+2 and res_valid at N+3. An exception detected at accept gives res_valid at N+1. op_ready_o=0 outside IDLE, so accept never overlaps a result.
- Strobes:
  - byte = 4'b0001 << addr[1:0]
  - half = 4'b0011 << addr[1:0]
  - word = 4'b1111
  - Loads drive strb=4'b1111 and data=0.
- Store data: byte drives {4{wdata[7:0]}}, half drives {2{wdata[15:0]}}, word drives wdata.
- Load extraction: shift = rsp_data >> (8*addr[1:0]). LB sign-extends shift[7:0], LBU zero-extends it; LH/LHU do the same on shift[15:0]; LW passes the word through. Stores return res_data_o=0.
- flush_i:
  - IDLE: block accept.
  - DONE: drop res_valid_o next cycle and go to IDLE.
  - REQ/RSP: set a kill flag. The handshake completes and the response is drained and discarded, then the FSM goes to IDLE with no res_valid. The kill flag clears on return to IDLE.
- rst_i mid-transaction: IDLE next cycle, all outputs 0, kill flag cleared. The memory side is reset on the same rst_i domain.

Test Plan:
- LW at 0x1000, rsp 0xDEADBEEF, no waits -> req size=010, strb=1111; res_data=0xDEADBEEF at accept+3, res_exc=0.
- LB at 0x1003, rsp 0x80FF_0000 -> res_data=0xFFFFFF80; the same case with LBU gives 0x00000080.
- SH at 0x2002, wdata 0x1234ABCD, data_req_ready_i low 3 cycles -> req held stable with data=0xABCDABCD, strb=1100, write=1; result data=0, no exception.
- LW at 0x1001 -> no data_req_valid_o; res_valid at accept+1 with exc=1, cause=4. SW at 0x1002 gives cause=6.
- LH at 0x10, rsp error=1 -> res_exc=1, cause=5, data=0. Funct3=011 load gives cause=5 with no memory request.
- flush_i asserted in RSP, rsp arrives 2 cycles later -> rsp_ready=1, no res_valid, back to IDLE with op_ready_o=1. rst_i asserted in REQ -> req_valid=0 and IDLE next cycle.
